// File: rtl/tff_ctrl_pkg.sv
// Shared encodings for the T flip-flop counter controller:
// FSM state values plus direction and mode constants.
package tff_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DN       = 1'b1;
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops: bit gi flips on the rising edge when t[gi]=1.
// Asynchronous active-low clear to zero.
module tff_bank #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_tff
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) q[gi] <= 1'b0;
            else if (t[gi]) q[gi] <= ~q[gi];
         end
      end
   endgenerate

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequences a T flip-flop bank as a programmable up/down counter running
// from a captured load value to a terminal value, one-shot or auto-reload.
module tff_count_ctrl
   import tff_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             dir,
   input  logic             mode,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] term_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   state_t           state_reg, state_next;
   logic             dir_reg, mode_reg;
   logic [WIDTH-1:0] load_reg, term_reg;
   logic             wrap_reg, wrap_next;
   logic             capture;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] up_tog, dn_tog, step_tog, load_tog;

   // Carry/borrow chains: a bit toggles when every lower bit is 1 (up) or 0 (down).
   assign up_tog[0] = 1'b1;
   assign dn_tog[0] = 1'b1;
   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_chain
         assign up_tog[gi] = up_tog[gi-1] &  count[gi-1];
         assign dn_tog[gi] = dn_tog[gi-1] & ~count[gi-1];
      end
   endgenerate

   assign step_tog = (dir_reg == DIR_DN) ? dn_tog : up_tog;
   assign load_tog = count ^ load_reg;

   always_comb begin
      state_next = state_reg;
      t          = '0;
      wrap_next  = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !stop) begin
               state_next = LOAD;
               capture    = 1'b1;
            end
         end
         LOAD: begin
            if (stop) begin
               state_next = IDLE;
            end else begin
               t          = load_tog;
               state_next = RUN;
            end
         end
         RUN: begin
            // stop outranks the terminal match, so no reload or done follows it
            if (stop) begin
               state_next = IDLE;
            end else if (count != term_reg) begin
               t = step_tog;
            end else if (mode_reg == MODE_RELOAD) begin
               t         = load_tog;
               wrap_next = 1'b1;
            end else begin
               state_next = DONE;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         dir_reg   <= DIR_UP;
         mode_reg  <= MODE_ONESHOT;
         load_reg  <= '0;
         term_reg  <= '0;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         wrap_reg  <= wrap_next;
         if (capture) begin
            dir_reg  <= dir;
            mode_reg <= mode;
            load_reg <= load_val;
            term_reg <= term_val;
         end
      end
   end

   tff_bank #(.WIDTH(WIDTH)) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .t       (t),
      .q       (count)
   );

   assign busy = (state_reg == LOAD) || (state_reg == RUN);
   assign done = (state_reg == DONE);
   assign wrap = wrap_reg;

endmodule
